// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, FSM state encoding and field helpers for data_cache
package cache_pkg;
    localparam int OFFSET_W = 2;
    localparam int BLOCK_W = 32;
    localparam int ADDR_W = 8;
    localparam int INDEX_W = 3;
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int TAG_LSB = INDEX_W + OFFSET_W;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FETCH = 2'd2;
    localparam logic [1:0] UPDATE = 2'd3;
    function automatic int tag_width(int aw, int iw);
        return aw - iw - OFFSET_W;
    endfunction
endpackage

// File: rtl/data_cache_if.sv
// data_cache_if: CPU-side and memory-side bus of the data cache
// slave = cache (takes read/write/address/writedata/mem_readdata/mem_busywait,
// drives readdata/busywait/mem_read/mem_write/mem_address/mem_writedata);
// master = surrounding CPU and memory
interface data_cache_if
    import cache_pkg::*;
#(
    parameter int ADDR_W = cache_pkg::ADDR_W
);
    logic read;
    logic write;
    logic [ADDR_W-1:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic busywait;
    logic mem_read;
    logic mem_write;
    logic [ADDR_W-OFFSET_W-1:0] mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic mem_busywait;
    modport slave (
        input read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );
    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/cache_fsm.sv
// cache_fsm: miss-handling state machine of data_cache
// ports: clk, reset (async active-low), request/hit/dirty from the lookup,
// mem_busywait from memory; state, mem_read, mem_write out
module cache_fsm
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       request,
    input  logic       hit,
    input  logic       dirty,
    input  logic       mem_busywait,
    output logic [1:0] state,
    output logic       mem_read,
    output logic       mem_write
);
    logic [1:0] nxt;
    always_comb begin
        nxt = state == IDLE      ? (request && !hit ? (dirty ? WRITEBACK : FETCH) : IDLE) :
              state == WRITEBACK ? (mem_busywait ? WRITEBACK : FETCH) :
              state == FETCH     ? (mem_busywait ? FETCH : UPDATE) : IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= nxt;
    end
    // decoded from the async-reset state so both requests drop the instant reset asserts
    assign mem_read = state == FETCH;
    assign mem_write = state == WRITEBACK;
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate byte data cache
// ports: clk, reset (async active-low), bus (data_cache_if.slave) carrying the
// CPU request/response and the 32-bit block memory interface
module data_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int INDEX_W = cache_pkg::INDEX_W
)(
    input logic clk,
    input logic reset,
    data_cache_if.slave bus
);
    localparam int TW = tag_width(ADDR_W, INDEX_W);
    localparam int BLOCKS = 1 << INDEX_W;
    localparam int TL = INDEX_W + OFFSET_W;
    logic [BLOCKS-1:0] valid, dirty;
    logic [TW-1:0] tags [BLOCKS];
    logic [BLOCK_W-1:0] data [BLOCKS];
    logic [TW-1:0] tag;
    logic [INDEX_W-1:0] idx;
    logic [OFFSET_W-1:0] off;
    logic [1:0] state;
    logic request, hit, idle, read_hit, write_hit, fill, mem_rd, mem_wr;
    logic [7:0] rd_byte, readdata_q;
    assign tag = bus.address[ADDR_W-1:TL];
    assign idx = bus.address[TL-1:OFFSET_W];
    assign off = bus.address[OFFSET_W-1:0];
    assign request = bus.read || bus.write;
    assign hit = valid[idx] && tags[idx] == tag;
    assign idle = state == IDLE;
    // write wins when both strobes are high, so a read hit needs write low
    assign read_hit = idle && bus.read && !bus.write && hit;
    assign write_hit = idle && bus.write && hit;
    assign fill = state == FETCH && !bus.mem_busywait;
    assign rd_byte = data[idx][{off, 3'b000} +: 8];
    cache_fsm fsm (
        .clk(clk),
        .reset(reset),
        .request(request),
        .hit(hit),
        .dirty(dirty[idx]),
        .mem_busywait(bus.mem_busywait),
        .state(state),
        .mem_read(mem_rd),
        .mem_write(mem_wr)
    );
    assign bus.mem_read = mem_rd;
    assign bus.mem_write = mem_wr;
    assign bus.readdata = read_hit ? rd_byte : readdata_q;
    // gated by reset so a request held through reset cannot raise a stall
    assign bus.busywait = reset && (idle ? request && !hit : 1'b1);
    assign bus.mem_address = state == WRITEBACK ? {tags[idx], idx} :
                             state == FETCH ? {tag, idx} : '0;
    assign bus.mem_writedata = state == WRITEBACK ? data[idx] : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            dirty <= '0;
            readdata_q <= '0;
        end else begin
            if (fill) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end else if (write_hit) dirty[idx] <= 1'b1;
            if (read_hit) readdata_q <= rd_byte;
        end
    end
    // block storage is qualified by valid, so it needs no reset
    always_ff @(posedge clk) begin
        if (fill) begin
            data[idx] <= bus.mem_readdata;
            tags[idx] <= tag;
        end else if (write_hit) data[idx][{off, 3'b000} +: 8] <= bus.writedata;
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed table and randomized model check of data_cache
module tb_data_cache;
    import cache_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    int lat = 3;
    int cnt;
    logic [31:0] mem [64];
    always #5 clk = ~clk;
    data_cache_if #(.ADDR_W(8)) bus();
    data_cache #(.ADDR_W(8), .INDEX_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));
    // block memory: busy for lat cycles per transfer, completes when busywait is low
    assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && cnt < lat;
    assign bus.mem_readdata = mem[bus.mem_address];
    always @(posedge clk or negedge reset) begin
        if (!reset) cnt <= 0;
        else if (bus.mem_read || bus.mem_write) begin
            cnt <= bus.mem_busywait ? cnt + 1 : 0;
            if (bus.mem_write && !bus.mem_busywait) mem[bus.mem_address] = bus.mem_writedata;
        end else cnt <= 0;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask
    logic hit0, saw_wb, saw_f, both, tmo;
    logic [7:0] rd;
    logic [5:0] wb_addr, f_addr;
    logic [31:0] wb_data;
    int cyc;
    task automatic req(input logic r, input logic w, input logic [7:0] a, input logic [7:0] wd);
        @(negedge clk);
        bus.read = r;
        bus.write = w;
        bus.address = a;
        bus.writedata = wd;
        #1;
        hit0 = !bus.busywait;
        cyc = 0;
        saw_wb = 0;
        saw_f = 0;
        both = 0;
        wb_addr = 0;
        wb_data = 0;
        f_addr = 0;
        while (bus.busywait && cyc < 300) begin
            if (bus.mem_write && !saw_wb) begin
                saw_wb = 1;
                wb_addr = bus.mem_address;
                wb_data = bus.mem_writedata;
            end
            if (bus.mem_read && !saw_f) begin
                saw_f = 1;
                f_addr = bus.mem_address;
            end
            if (bus.mem_read && bus.mem_write) both = 1;
            @(negedge clk);
            #1;
            cyc++;
        end
        tmo = bus.busywait;
        rd = bus.readdata;
        @(posedge clk);
        #1;
        bus.read = 0;
        bus.write = 0;
    endtask
    typedef struct {
        logic r;
        logic w;
        logic [7:0] a;
        logic [7:0] wd;
        logic hit;
        logic chk_rd;
        logic [7:0] rd;
        logic wb;
        logic [5:0] wb_addr;
        logic [31:0] wb_data;
        logic [5:0] f_addr;
        int cyc;
    } vec_t;
    vec_t tbl [9];
    logic [7:0] refm [256];
    logic vld [8];
    logic drt [8];
    logic [2:0] tg [8];
    initial begin
        bus.read = 0;
        bus.write = 0;
        bus.address = 0;
        bus.writedata = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h44332211;
        mem[8] = 32'h88776655;
        mem[63] = 32'hDEADBEEF;
        tbl[0] = '{1, 0, 8'h00, 8'h00, 0, 1, 8'h11, 0, 6'h00, 32'h0, 6'h00, 6};
        tbl[1] = '{1, 0, 8'h03, 8'h00, 1, 1, 8'h44, 0, 6'h00, 32'h0, 6'h00, 0};
        tbl[2] = '{0, 1, 8'h01, 8'hAB, 1, 0, 8'h00, 0, 6'h00, 32'h0, 6'h00, 0};
        tbl[3] = '{1, 0, 8'h01, 8'h00, 1, 1, 8'hAB, 0, 6'h00, 32'h0, 6'h00, 0};
        tbl[4] = '{1, 0, 8'h21, 8'h00, 0, 1, 8'h66, 1, 6'h00, 32'h4433AB11, 6'h08, 10};
        tbl[5] = '{1, 1, 8'h22, 8'h5A, 1, 0, 8'h00, 0, 6'h00, 32'h0, 6'h00, 0};
        tbl[6] = '{1, 0, 8'h22, 8'h00, 1, 1, 8'h5A, 0, 6'h00, 32'h0, 6'h00, 0};
        tbl[7] = '{1, 0, 8'h02, 8'h00, 0, 1, 8'h33, 1, 6'h08, 32'h885A6655, 6'h00, 10};
        tbl[8] = '{1, 0, 8'hFF, 8'h00, 0, 1, 8'hDE, 0, 6'h00, 32'h0, 6'h3F, 6};
        repeat (2) @(negedge clk);
        chk("rst_busywait", bus.busywait, 0);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_readdata", bus.readdata, 0);
        chk("rst_mem_address", bus.mem_address, 0);
        chk("rst_mem_writedata", bus.mem_writedata, 0);
        reset = 1;
        for (int i = 0; i < 9; i++) begin
            req(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd);
            chk($sformatf("v%0d_timeout", i), tmo, 0);
            chk($sformatf("v%0d_hit", i), hit0, tbl[i].hit);
            chk($sformatf("v%0d_wb", i), saw_wb, tbl[i].wb);
            chk($sformatf("v%0d_both", i), both, 0);
            if (tbl[i].wb) begin
                chk($sformatf("v%0d_wb_addr", i), wb_addr, tbl[i].wb_addr);
                chk($sformatf("v%0d_wb_data", i), wb_data, tbl[i].wb_data);
            end
            if (!tbl[i].hit) begin
                chk($sformatf("v%0d_f_addr", i), f_addr, tbl[i].f_addr);
                chk($sformatf("v%0d_cycles", i), cyc, tbl[i].cyc);
            end
            if (tbl[i].chk_rd) chk($sformatf("v%0d_rd", i), rd, tbl[i].rd);
        end
        repeat (3) @(negedge clk);
        chk("hold_readdata", bus.readdata, 8'hDE);
        lat = 6;
        @(negedge clk);
        bus.read = 1;
        bus.address = 8'h10;
        cyc = 0;
        while (!bus.mem_read && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_saw_fetch", bus.mem_read, 1);
        @(negedge clk);
        #2 reset = 0;
        #1;
        chk("rst_mid_mem_read", bus.mem_read, 0);
        chk("rst_mid_busywait", bus.busywait, 0);
        chk("rst_mid_mem_address", bus.mem_address, 0);
        chk("rst_mid_readdata", bus.readdata, 0);
        @(negedge clk);
        reset = 1;
        bus.read = 0;
        lat = 2;
        req(1, 0, 8'h00, 8'h00);
        chk("post_rst_hit", hit0, 0);
        chk("post_rst_timeout", tmo, 0);
        chk("post_rst_rd", rd, 8'h11);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int i = 0; i < 256; i++) refm[i] = mem[i / 4][(i % 4) * 8 +: 8];
        for (int i = 0; i < 8; i++) begin
            vld[i] = 0;
            drt[i] = 0;
            tg[i] = 0;
        end
        @(negedge clk);
        reset = 1;
        for (int n = 0; n < 300; n++) begin
            logic [2:0] t, x;
            logic [1:0] o;
            logic [7:0] a, wd;
            int op;
            logic eh, ew;
            logic [7:0] wb_base;
            t = 3'($urandom_range(0, 2));
            x = 3'($urandom_range(0, 7));
            o = 2'($urandom_range(0, 3));
            a = {t, x, o};
            wd = 8'($urandom);
            op = $urandom_range(0, 2);
            lat = $urandom_range(0, 3);
            eh = vld[x] && tg[x] == t;
            ew = !eh && vld[x] && drt[x];
            wb_base = {tg[x], x, 2'b00};
            req(op != 1, op != 0, a, wd);
            chk("rnd_timeout", tmo, 0);
            chk("rnd_hit", hit0, eh);
            chk("rnd_wb", saw_wb, ew);
            chk("rnd_both", both, 0);
            if (ew) begin
                chk("rnd_wb_addr", wb_addr, wb_base[7:2]);
                chk("rnd_wb_data", wb_data, {refm[wb_base + 3], refm[wb_base + 2], refm[wb_base + 1], refm[wb_base]});
            end
            if (!eh) chk("rnd_f_addr", f_addr, a[7:2]);
            if (op == 0) chk("rnd_rd", rd, refm[a]);
            if (!eh) begin
                vld[x] = 1;
                tg[x] = t;
                drt[x] = 0;
            end
            if (op != 0) begin
                refm[a] = wd;
                drt[x] = 1;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU datapath and the 32-bit-block data memory.
- The ALU result (ADD/AND/OR/MOV output) drives ADDRESS. The register-file output drives WRITEDATA. READDATA returns to the register-file write mux.
- BUSYWAIT stalls the PC and register file during misses.

Parameters:
- ADDR_W, 8, byte address width.
- INDEX_W, 3, index bits; 2^INDEX_W blocks of 4 bytes each; tag width = ADDR_W-INDEX_W-2.

Ports:
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  ADDR_W  byte address; split as tag [ADDR_W-1:INDEX_W+2], index [INDEX_W+1:2], offset [1:0].
- WRITEDATA  in  8  store byte.
- READDATA  out  8  load byte.
- BUSYWAIT  out  1  stall request to the CPU.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  ADDR_W-2  block address {tag,index}.
- MEM_WRITEDATA  out  32  victim block; byte0 = bits [7:0].
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory busy; low = transfer complete this cycle.

Behaviour:
- Storage per block: valid, dirty, tag, 32-bit data.
- Reset (RESET=0, asynchronous): all valid=0 and dirty=0; state=IDLE; BUSYWAIT, MEM_READ, MEM_WRITE = 0; READDATA=0; MEM_ADDRESS=0; MEM_WRITEDATA=0. Data arrays need not be cleared.
- Reset mid-miss: the miss is aborted immediately and MEM_READ/MEM_WRITE drop in the same instant. Memory may complete a stale transfer; the cache ignores it.
- Request: READ|WRITE. If both are high, WRITE has priority and READ is ignored.
- hit = valid[index] && tag[index]==tag. Evaluated combinationally in IDLE.
- BUSYWAIT = request && !hit in IDLE, or any non-IDLE state. It is combinational, so the CPU sees the stall in the same cycle.
- Read hit: READDATA = selected byte, combinationally in the same cycle; BUSYWAIT=0; zero-cycle latency.
- Write hit: the byte is written at the next rising edge and dirty[index] is set; BUSYWAIT=0.
- No request: READDATA holds its last value; no state changes.
- FSM states:
  - IDLE:
    - request && !hit && dirty[index] -> WRITEBACK.
    - request && !hit && !dirty[index] -> FETCH.
    - otherwise stay in IDLE.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=victim block. Leaves on the rising edge with MEM_BUSYWAIT=0 -> FETCH.
  - FETCH: MEM_READ=1, MEM_ADDRESS={request tag,index}. Leaves on the rising edge with MEM_BUSYWAIT=0 -> UPDATE.
  - UPDATE:
    - That edge latches MEM_READDATA into the block, sets valid=1, dirty=0, tag=request tag.
    - The following edge returns to IDLE, where the request re-evaluates as a hit and completes as a read or write hit.
  - MEM_READ and MEM_WRITE are never high together, and both are 0 in IDLE and UPDATE.
- Miss latency (clean): 1 FETCH cycle per memory wait + 1 UPDATE cycle + hit cycle.
- The CPU holds ADDRESS, READ, WRITE and WRITEDATA stable while BUSYWAIT=1. Changes during a miss are undefined.
- Index wrap: address 0xFF maps to index 7, offset 3. The tag compare covers the full tag, so there is no aliasing across tags.
- The memory side is also clocked by CLK.

Decomposition:
- Shared package (cache_pkg):
  - state encoding: IDLE=0, WRITEBACK=1, FETCH=2, UPDATE=3.
  - OFFSET_W=2 and BLOCK_W=32.
  - field-extraction constants derived from ADDR_W/INDEX_W.
- One natural sub-module: cache_fsm. It holds the state register, next-state logic and memory-side control. data_cache keeps the arrays, hit logic and byte select/merge.

Test Plan:
- Reset then READ addr 0x00, memory returns 0x44332211 after 3 wait cycles -> BUSYWAIT high, MEM_READ=1 with MEM_ADDRESS=0x00, then UPDATE, then READDATA=0x11 and BUSYWAIT low; MEM_WRITE stays 0 throughout.
- Following READ 0x03 -> hit in the same cycle, READDATA=0x44, no memory activity.
- WRITE 0xAB to 0x01 (hit) -> BUSYWAIT stays 0. A subsequent READ 0x01 returns 0xAB.
- READ 0x21 (same index 0, new tag, dirty victim):
  - WRITEBACK first: MEM_WRITE=1, MEM_ADDRESS=0x00, MEM_WRITEDATA=0x4433AB11.
  - Then FETCH with MEM_ADDRESS=0x08.
  - Then READDATA = byte1 of the fetched block.
- READ and WRITE both high on a hit -> only the write occurs; dirty is set.
- RESET low during FETCH -> MEM_READ and BUSYWAIT drop asynchronously, state returns to IDLE. The next READ 0x00 misses again because valid was cleared.
